// File: rtl/multicycle_controller.sv
// multicycle_controller: control FSM for a multicycle RISC-V core that shares
// one ALU and one unified memory across the phases of each instruction.
// Drives datapath selects, handshakes with memory (with a watchdog) and
// counts retired instructions.
module multicycle_controller #(
    parameter int MAX_WAIT = 16,
    parameter int CNT_W    = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [6:0]       opcode,
    input  logic             zero,
    input  logic             mem_ready,
    output logic             mem_req,
    output logic             mem_write,
    output logic             adr_src,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       result_src,
    output logic             illegal_op,
    output logic             bus_error,
    output logic [3:0]       state_o,
    output logic [CNT_W-1:0] retire_count
);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    // Wait counter only needs to reach MAX_WAIT-1; the timeout fires on the
    // cycle that would bring it to MAX_WAIT.
    localparam int                WAIT_W    = (MAX_WAIT > 0) ? $clog2(MAX_WAIT + 1) : 1;
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((MAX_WAIT > 0) ? MAX_WAIT - 1 : 0);
    localparam logic              WDOG_EN   = (MAX_WAIT > 0);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXEC_R   = 4'd6,
        S_EXEC_I   = 4'd7,
        S_ALUWB    = 4'd8,
        S_BRANCH   = 4'd9,
        S_HALT     = 4'd10
    } state_t;

    state_t            state_q, state_d;
    logic [WAIT_W-1:0] wait_q, wait_d;
    logic [CNT_W-1:0]  retire_q, retire_d;
    logic              bus_error_q, bus_error_d;
    logic              req_raw;
    logic              timeout;
    logic              retire;

    // Request states, independent of the reset mask so the watchdog sees them.
    assign req_raw = (state_q == S_FETCH) || (state_q == S_MEMREAD) || (state_q == S_MEMWRITE);
    assign timeout = WDOG_EN && req_raw && !mem_ready && (wait_q == WAIT_LAST);

    assign state_o      = state_q;
    assign bus_error    = bus_error_q;
    assign retire_count = retire_q;

    // Next state, Moore control decode, and retire strobe; all controls masked in reset.
    always_comb begin
        state_d    = state_q;
        retire     = 1'b0;
        mem_req    = 1'b0;
        mem_write  = 1'b0;
        adr_src    = 1'b0;
        ir_write   = 1'b0;
        pc_write   = 1'b0;
        reg_write  = 1'b0;
        alu_src_a  = 2'b00;
        alu_src_b  = 2'b00;
        alu_op     = 2'b00;
        result_src = 2'b00;
        illegal_op = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_req    = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                if (mem_ready) begin
                    ir_write = 1'b1;
                    pc_write = 1'b1;
                    state_d  = S_DECODE;
                end
            end
            S_DECODE: begin
                // Branch target (oldPC + imm) lands in ALUOut for BRANCH.
                alu_src_a = 2'b01;
                alu_src_b = 2'b01;
                case (opcode)
                    OP_LW, OP_SW: state_d = S_MEMADR;
                    OP_R:         state_d = S_EXEC_R;
                    OP_I:         state_d = S_EXEC_I;
                    OP_BEQ:       state_d = S_BRANCH;
                    default: begin
                        illegal_op = 1'b1;
                        state_d    = S_FETCH;
                    end
                endcase
            end
            S_MEMADR: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                state_d   = (opcode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
            end
            S_MEMREAD: begin
                mem_req = 1'b1;
                adr_src = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                result_src = 2'b01;
                reg_write  = 1'b1;
                retire     = 1'b1;
                state_d    = S_FETCH;
            end
            S_MEMWRITE: begin
                mem_req   = 1'b1;
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (mem_ready) begin
                    retire  = 1'b1;
                    state_d = S_FETCH;
                end
            end
            S_EXEC_R: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_EXEC_I: begin
                alu_src_a = 2'b10;
                alu_src_b = 2'b01;
                alu_op    = 2'b10;
                state_d   = S_ALUWB;
            end
            S_ALUWB: begin
                reg_write = 1'b1;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_BRANCH: begin
                alu_src_a = 2'b10;
                alu_op    = 2'b01;
                pc_write  = zero;
                retire    = 1'b1;
                state_d   = S_FETCH;
            end
            S_HALT: state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
        if (timeout) state_d = S_HALT;
        if (rst) begin
            mem_req    = 1'b0;
            mem_write  = 1'b0;
            adr_src    = 1'b0;
            ir_write   = 1'b0;
            pc_write   = 1'b0;
            reg_write  = 1'b0;
            alu_src_a  = 2'b00;
            alu_src_b  = 2'b00;
            alu_op     = 2'b00;
            result_src = 2'b00;
            illegal_op = 1'b0;
        end
    end

    // Watchdog count, sticky bus error, and wrapping retire counter.
    always_comb begin
        wait_d      = (req_raw && !mem_ready && state_d == state_q) ? wait_q + WAIT_W'(1) : '0;
        bus_error_d = bus_error_q | timeout;
        retire_d    = retire ? retire_q + CNT_W'(1) : retire_q;
    end

    // State and counters; reset has priority so an abandoned instruction never retires.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_FETCH;
            wait_q      <= '0;
            retire_q    <= '0;
            bus_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            retire_q    <= retire_d;
            bus_error_q <= bus_error_d;
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// tb_multicycle_controller: directed scenarios with literal expectations plus
// a randomized run, all shadowed every cycle by a behavioural model.
module tb_multicycle_controller;

    localparam int MAXW = 4;
    localparam int CNTW = 4;
    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BEQ = 7'b1100011;

    logic clk = 1'b0;
    logic rst, zero, mem_ready;
    logic [6:0] opcode;
    logic mem_req, mem_write, adr_src, ir_write, pc_write, reg_write, illegal_op, bus_error;
    logic [1:0] alu_src_a, alu_src_b, alu_op, result_src;
    logic [3:0] state_o;
    logic [CNTW-1:0] retire_count;

    int checks = 0;
    int errors = 0;

    multicycle_controller #(.MAX_WAIT(MAXW), .CNT_W(CNTW)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .mem_req(mem_req), .mem_write(mem_write), .adr_src(adr_src), .ir_write(ir_write),
        .pc_write(pc_write), .reg_write(reg_write), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .result_src(result_src),
        .illegal_op(illegal_op), .bus_error(bus_error), .state_o(state_o),
        .retire_count(retire_count)
    );

    always #5 clk = ~clk;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endfunction

    function automatic logic legal(logic [6:0] op);
        return op inside {OP_LW, OP_SW, OP_R, OP_I, OP_BEQ};
    endfunction

    // ---------------- behavioural model ----------------
    // Moore control table per state number:
    // {mem_req, mem_write, adr_src, reg_write, alu_src_a, alu_src_b, alu_op, result_src}
    logic [11:0] moore [0:10];
    initial begin
        moore[0]  = 12'b1000_0010_0010;  // fetch: PC+4, PC as address
        moore[1]  = 12'b0000_0101_0000;  // decode: oldPC+imm
        moore[2]  = 12'b0000_1001_0000;  // memadr: rs1+imm
        moore[3]  = 12'b1010_0000_0000;  // memread
        moore[4]  = 12'b0001_0000_0001;  // memwb from MDR
        moore[5]  = 12'b1110_0000_0000;  // memwrite
        moore[6]  = 12'b0000_1000_1000;  // exec R
        moore[7]  = 12'b0000_1001_1000;  // exec I
        moore[8]  = 12'b0001_0000_0000;  // aluwb from ALUOut
        moore[9]  = 12'b0000_1000_0100;  // branch compare
        moore[10] = 12'b0000_0000_0000;  // halt
    end

    function automatic int nxt(int st, logic rdy, logic [6:0] op);
        case (st)
            0: return rdy ? 1 : 0;
            1: begin
                if (op == OP_LW || op == OP_SW) return 2;
                if (op == OP_R)   return 6;
                if (op == OP_I)   return 7;
                if (op == OP_BEQ) return 9;
                return 0;
            end
            2: return (op == OP_LW) ? 3 : 5;
            3: return rdy ? 4 : 3;
            5: return rdy ? 0 : 5;
            6, 7: return 8;
            4, 8, 9: return 0;
            default: return 10;
        endcase
    endfunction

    int   m_state = 0;
    int   m_wait  = 0;
    int   m_cnt   = 0;
    logic m_berr  = 1'b0;
    logic [11:0] e_ctl;
    logic e_ir, e_pc, e_ill, m_req, m_ret, m_tmo;
    int   m_nx;

    // Compare every cycle, then advance the model with this cycle's inputs.
    always @(negedge clk) begin
        if (rst) begin
            e_ctl = '0; e_ir = 1'b0; e_pc = 1'b0; e_ill = 1'b0;
        end else begin
            e_ctl = moore[m_state];
            e_ir  = (m_state == 0) && mem_ready;
            e_pc  = e_ir || ((m_state == 9) && zero);
            e_ill = (m_state == 1) && !legal(opcode);
        end
        chk("m_ctl", 32'({mem_req, mem_write, adr_src, reg_write, alu_src_a, alu_src_b, alu_op, result_src}), 32'(e_ctl));
        chk("m_strobe", 32'({ir_write, pc_write, illegal_op}), 32'({e_ir, e_pc, e_ill}));
        chk("m_state", 32'(state_o), m_state);
        chk("m_bus_error", 32'(bus_error), 32'(m_berr));
        chk("m_retire", 32'(retire_count), m_cnt);
        if (rst) begin
            m_state = 0; m_wait = 0; m_cnt = 0; m_berr = 1'b0;
        end else begin
            m_req  = moore[m_state][11];
            m_ret  = (m_state == 4) || (m_state == 8) || (m_state == 9) || ((m_state == 5) && mem_ready);
            m_tmo  = (MAXW != 0) && m_req && !mem_ready && (m_wait + 1 >= MAXW);
            m_nx   = m_tmo ? 10 : nxt(m_state, mem_ready, opcode);
            m_wait = (m_req && !mem_ready && m_nx == m_state) ? m_wait + 1 : 0;
            if (m_tmo) m_berr = 1'b1;
            m_cnt  = (m_cnt + (m_ret ? 1 : 0)) % (1 << CNTW);
            m_state = m_nx;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // ---------------- directed + random stimulus ----------------
    initial begin
        int seq_addi[4];
        int seq_lw[10];
        int seq_sw[7];
        int irc, adrc, rwc, rwok, illc;
        seq_addi = '{0, 1, 7, 8};
        seq_lw   = '{0, 0, 0, 0, 1, 2, 3, 3, 3, 4};
        seq_sw   = '{0, 1, 2, 5, 5, 5, 5};

        rst = 1'b1; opcode = OP_I; zero = 1'b0; mem_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        chk("rst_state", 32'(state_o), 0);
        chk("rst_retire", 32'(retire_count), 0);
        chk("rst_bus_error", 32'(bus_error), 0);
        chk("rst_ctl", 32'({mem_req, ir_write, pc_write, reg_write, alu_src_b, result_src}), 0);
        step();

        // addi with memory always ready
        rst = 1'b0; opcode = OP_I; mem_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("addi_state", 32'(state_o), seq_addi[i]);
            chk("addi_regw", 32'(reg_write), 32'(i == 3));
            step();
        end

        // lw: 3 wait cycles in FETCH, 2 in MEMREAD
        opcode = OP_LW; irc = 0; adrc = 0; rwc = 0; rwok = 0;
        for (int i = 0; i < 10; i++) begin
            mem_ready = (i == 3 || i == 8);
            @(negedge clk);
            if (i == 0) chk("addi_retire", 32'(retire_count), 1);
            chk("lw_state", 32'(state_o), seq_lw[i]);
            irc += int'(ir_write);
            if (state_o == 4'd3 && adr_src) adrc++;
            if (reg_write) begin
                rwc++;
                if (result_src == 2'b01) rwok++;
            end
            step();
        end
        chk("lw_ir_pulses", irc, 1);
        chk("lw_adr_src", adrc, 3);
        chk("lw_regw", rwc, 1);
        chk("lw_result_src", rwok, 1);

        // beq taken then not taken
        opcode = OP_BEQ; mem_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            zero = (k == 0);
            for (int i = 0; i < 3; i++) begin
                @(negedge clk);
                if (i == 0 && k == 0) chk("lw_retire", 32'(retire_count), 2);
                if (i == 2) begin
                    chk("beq_state", 32'(state_o), 9);
                    chk("beq_pc_write", 32'(pc_write), 32'(k == 0));
                end
                step();
            end
        end

        // illegal opcode
        opcode = 7'h7f; illc = 0; zero = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            if (i == 0) chk("beq_retire", 32'(retire_count), 4);
            if (i == 1) chk("ill_state", 32'(state_o), 1);
            illc += int'(illegal_op);
            step();
        end
        chk("ill_pulses", illc, 1);

        // sw with memory never answering: watchdog halts the core
        opcode = OP_SW;
        for (int i = 0; i < 7; i++) begin
            mem_ready = (i < 3);
            @(negedge clk);
            if (i == 0) chk("ill_retire", 32'(retire_count), 4);
            chk("tmo_state", 32'(state_o), seq_sw[i]);
            chk("tmo_berr_pre", 32'(bus_error), 0);
            step();
        end
        mem_ready = 1'b1; zero = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("halt_state", 32'(state_o), 10);
            chk("halt_berr", 32'(bus_error), 1);
            chk("halt_ctl", 32'({mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
                                 alu_src_a, alu_src_b, alu_op, result_src, illegal_op}), 0);
            chk("halt_retire", 32'(retire_count), 4);
            step();
        end
        rst = 1'b1;
        @(negedge clk);
        step();

        // sw with ready on the 4th MEMWRITE cycle: no error
        rst = 1'b0;
        for (int i = 0; i < 7; i++) begin
            mem_ready = (i < 3 || i == 6);
            @(negedge clk);
            if (i == 0) begin
                chk("rst_clr_berr", 32'(bus_error), 0);
                chk("rst_clr_retire", 32'(retire_count), 0);
            end
            chk("late_rdy_state", 32'(state_o), seq_sw[i]);
            step();
        end

        // reset in MEMREAD abandons the load
        opcode = OP_LW;
        for (int i = 0; i < 4; i++) begin
            mem_ready = (i == 0);
            @(negedge clk);
            if (i == 0) begin
                chk("late_rdy_next", 32'(state_o), 0);
                chk("late_rdy_berr", 32'(bus_error), 0);
                chk("late_rdy_retire", 32'(retire_count), 1);
            end
            if (i == 3) chk("memread_state", 32'(state_o), 3);
            step();
        end
        rst = 1'b1; mem_ready = 1'b1;
        @(negedge clk);
        chk("rst_mid_regw", 32'(reg_write), 0);
        chk("rst_mid_pcw", 32'(pc_write), 0);
        chk("rst_mid_req", 32'(mem_req), 0);
        step();

        // 16 addi wrap the 4-bit retire counter
        rst = 1'b0; opcode = OP_I; mem_ready = 1'b1;
        for (int k = 0; k < 64; k++) begin
            @(negedge clk);
            if (k == 0) begin
                chk("rst_mid_state", 32'(state_o), 0);
                chk("rst_mid_retire", 32'(retire_count), 0);
            end
            if (k == 60) chk("wrap_pre", 32'(retire_count), 15);
            step();
        end
        @(negedge clk);
        chk("wrap", 32'(retire_count), 0);
        chk("wrap_state", 32'(state_o), 0);
        step();

        // randomized traffic; opcode only changes while fetching
        for (int c = 0; c < 4000; c++) begin
            if (m_state == 10) rst = ($urandom_range(0, 3) == 0);
            else               rst = ($urandom_range(0, 199) == 0);
            mem_ready = ($urandom_range(0, 9) < 7);
            zero      = 1'($urandom_range(0, 1));
            if (m_state == 0) begin
                case ($urandom_range(0, 9))
                    0, 1:    opcode = OP_LW;
                    2:       opcode = OP_SW;
                    3, 4:    opcode = OP_R;
                    5, 6:    opcode = OP_I;
                    7, 8:    opcode = OP_BEQ;
                    default: opcode = 7'($urandom_range(0, 127));
                endcase
            end
            @(negedge clk);
            step();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
Name: multicycle_controller

Overview:
- Control FSM that sequences the shared RISC-V datapath (one ALU, one unified instruction/data memory, IR, ALUOut and MDR registers) over several cycles per instruction.
- Supports R-type, lw, sw, beq and addi, using the team's existing ALUOp encoding.
- Handshakes with the memory through mem_req/mem_ready, with a watchdog that halts the core on an unanswered request.
- Counts retired instructions.

Parameters:
- MAX_WAIT, 16, max cycles a memory request may wait for mem_ready; 0 disables the watchdog.
- CNT_W, 32, width of retire_count.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- opcode  in  7  IR[6:0]; stable from DECODE onward.
- zero  in  1  ALU zero flag.
- mem_ready  in  1  memory completes the current request this cycle.
- mem_req  out  1  memory request valid.
- mem_write  out  1  request is a write.
- adr_src  out  1  address select: 0=PC, 1=ALUOut.
- ir_write  out  1  load IR and oldPC.
- pc_write  out  1  load PC from result bus.
- reg_write  out  1  register file write enable.
- alu_src_a  out  2  00=PC, 01=oldPC, 10=rs1.
- alu_src_b  out  2  00=rs2, 01=imm, 10=const 4.
- alu_op  out  2  00=add, 01=sub/branch, 10=funct-decoded.
- result_src  out  2  00=ALUOut, 01=MDR, 10=ALU result.
- illegal_op  out  1  one-cycle pulse for an unsupported opcode.
- bus_error  out  1  sticky watchdog timeout flag.
- state_o  out  4  current state, for debug.
- retire_count  out  CNT_W  retired-instruction counter.

Behaviour:
- Reset:
  - While rst=1 at a clock edge: state<=FETCH, wait counter<=0, retire_count<=0, bus_error<=0.
  - While rst=1, every control output is forced to 0 combinationally.
  - The first cycle after deassertion is FETCH.
  - rst mid-instruction abandons it; no pc_write or reg_write occurs.
- Outputs are Moore decodes of state, except ir_write, pc_write and state exits, which are qualified by mem_ready or zero as stated below.
- Any output not listed for a state is 0.
- States and encodings: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXEC_R=6, EXEC_I=7, ALUWB=8, BRANCH=9, HALT=10.
- FETCH:
  - Outputs: mem_req=1, adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10.
  - When mem_ready=1: ir_write=1, pc_write=1, next state DECODE. Otherwise stay in FETCH.
- DECODE:
  - Outputs: alu_src_a=01, alu_src_b=01, alu_op=00 (branch target into ALUOut).
  - Next state by opcode: 0000011 or 0100011 -> MEMADR; 0110011 -> EXEC_R; 0010011 -> EXEC_I; 1100011 -> BRANCH.
  - Any other opcode: illegal_op=1 this cycle, next state FETCH, not retired.
- MEMADR: alu_src_a=10, alu_src_b=01, alu_op=00; next state MEMREAD if opcode=lw, else MEMWRITE.
- MEMREAD: mem_req=1, adr_src=1; stay until mem_ready=1, then MEMWB.
- MEMWB: result_src=01, reg_write=1; next state FETCH; retire.
- MEMWRITE: mem_req=1, mem_write=1, adr_src=1; stay until mem_ready=1, then FETCH; retire on that exit.
- EXEC_R: alu_src_a=10, alu_src_b=00, alu_op=10; next state ALUWB.
- EXEC_I: alu_src_a=10, alu_src_b=01, alu_op=10; next state ALUWB.
- ALUWB: result_src=00, reg_write=1; next state FETCH; retire.
- BRANCH:
  - Outputs: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, pc_write=zero.
  - Next state FETCH; retire.
- CPI: R/addi/beq 3–4 cycles, sw 4, lw 5, each plus memory wait cycles.
- Watchdog:
  - The wait counter increments on each cycle with mem_req=1 and mem_ready=0; it clears on mem_ready=1 or on a state change.
  - When the counter reaches MAX_WAIT with mem_ready still 0 (MAX_WAIT≠0): bus_error<=1, next state HALT.
  - mem_ready=1 arriving in the same cycle the counter reaches MAX_WAIT wins; no error is raised.
- HALT: all control outputs 0; stays in HALT until rst.
- retire_count: +1 on each retire cycle, wraps modulo 2^CNT_W.
- mem_req holds at 1 without gaps until mem_ready is seen; mem_write and adr_src are stable throughout the request.

Test Plan:
- addi x1,x0,5 (opcode 0010011), mem_ready tied 1 -> state sequence 0,1,7,8,0; reg_write=1 only in ALUWB; retire_count 0->1.
- lw with mem_ready delayed 3 cycles in FETCH and 2 cycles in MEMREAD -> ir_write a single pulse on the ready cycle; adr_src=1 throughout MEMREAD; 10 cycles total; reg_write in MEMWB with result_src=01.
- beq with zero=1, then with zero=0 -> pc_write=1 in BRANCH for the first only; both retire, retire_count=2.
- opcode 1111111 -> illegal_op pulses once in DECODE; next state FETCH; retire_count unchanged.
- MAX_WAIT=4, mem_ready held 0 in MEMWRITE -> bus_error=1 after 4 waiting cycles; state=10; all outputs 0 until rst; mem_ready=1 on the 4th cycle instead -> no error.
- rst asserted in MEMREAD -> next cycle state=FETCH, retire_count=0, no reg_write pulse; CNT_W=4 run of 16 addi -> retire_count wraps to 0.
